id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the pipelined RISC-V core.
- Sits directly downstream of the register file. It captures the two read operands, the decoded immediate and control, the PC and the register indices on each clock.
- Provides WB-to-ID write-through bypass. The register file writes on the clock edge, so a same-cycle read returns the old value; this block corrects that.
- Detects load-use hazards, inserts bubbles, and honours downstream hold and branch flush.

Parameters:
- CTRL_W, 8, width of opaque decoded control bundle passed to EX
- CNT_W, 16, width of saturating bubble counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_pc  in  32  PC of ID instruction
- id_imm  in  32  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5 each  source/destination indices
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2
- id_memread, id_regwrite  in  1 each  load / writes-rd flags
- id_ctrl  in  CTRL_W  remaining decoded control
- rf_rd1, rf_rd2  in  32 each  register file read_data_1/read_data_2 for id_rs1/id_rs2
- wb_regwrite  in  1  WB stage writing register file this cycle
- wb_rd  in  5  WB destination
- wb_data  in  32  WB write data
- flush  in  1  taken branch/jump resolved in EX; kill ID instruction
- ex_hold  in  1  EX busy (multi-cycle op); freeze this stage
- id_stall  out  1  combinational; hold PC and IF/ID register
- ex_valid  out  1  EX instruction valid
- ex_pc, ex_imm  out  32 each
- ex_rs1, ex_rs2, ex_rd  out  5 each
- ex_op1, ex_op2  out  32 each  operands after bypass
- ex_memread, ex_regwrite  out  1 each
- ex_ctrl  out  CTRL_W
- bubble_cnt  out  CNT_W  load-use bubbles inserted

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset sets every registered output to 0: ex_valid, ex_memread, ex_regwrite, ex_ctrl, ex_pc, ex_imm, ex_rs1/rs2/rd, ex_op1/op2 and bubble_cnt.
- load_use (combinational) = id_valid & ex_valid & ex_memread & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- id_stall = (load_use | ex_hold) & ~flush. It is purely combinational, with no register in the path.
- Bypass: byp1 = (wb_regwrite & wb_rd != 0 & wb_rd == id_rs1) ? wb_data : rf_rd1. byp2 is the same using id_rs2/rf_rd2. A write to index 0 is never bypassed.
- Per rising edge, first matching rule wins:
  1. rst: clear all state as above.
  2. flush: load a bubble. ex_valid, ex_memread, ex_regwrite and ex_ctrl become 0; the other fields hold. bubble_cnt is unchanged. Flush overrides ex_hold and load_use.
  3. ex_hold: all EX fields hold. Exception (operand refresh): if ex_valid & wb_regwrite & wb_rd != 0 & wb_rd == ex_rs1, ex_op1 <= wb_data; same for ex_rs2/ex_op2. bubble_cnt is unchanged.
  4. load_use: load a bubble (as in rule 2). bubble_cnt increments, saturating at all-ones.
  5. Otherwise capture:
     - ex_valid <= id_valid.
     - ex_memread, ex_regwrite and ex_ctrl take the id_ values when id_valid, else 0.
     - pc, imm and indices are copied.
     - ex_op1 <= byp1, ex_op2 <= byp2.
- Latency: one cycle ID to EX. A load-use pair costs exactly one bubble. The stall drops the cycle after the bubble, because ex_memread is then 0.
- Control outputs are never asserted while ex_valid = 0.
- Unused-source false hazards are avoided via id_use_rs1/id_use_rs2.
- A mid-operation rst discards the held and in-flight instruction with no residue.

Test Plan:
- Reset: rst=1 for one edge with arbitrary inputs -> all outputs 0, id_stall=0.
- Capture plus bypass: rf_rd1=0x5, id_rs1=6, wb_regwrite=1, wb_rd=6, wb_data=0xAB; rf_rd2=0x7, id_rs2=7 -> next cycle ex_op1=0xAB, ex_op2=0x7, ex_valid=1. Repeat with wb_rd=0 -> ex_op1=0x5.
- Load-use: EX holds load to x3 (ex_memread=1, ex_rd=3); ID reads rs2=3 with id_use_rs2=1 -> id_stall=1, next edge ex_valid=0 and bubble_cnt=1. Following edge captures the ID instruction and id_stall=0. Same case with id_use_rs2=0 -> no stall.
- Hold with refresh: ex_valid=1, ex_rs1=9, ex_hold=1 for 3 cycles; in cycle 2 wb writes x9=0x1234 -> ex_op1=0x1234, all other fields unchanged, id_stall=1 throughout.
- Flush priority: flush=1 together with ex_hold=1 and a load_use condition -> next edge ex_valid=0, ex_regwrite=0, bubble_cnt unchanged, id_stall=0 during the flush cycle.
- Counter saturation: preload via 0xFFFF consecutive load_use bubbles (or CNT_W=4 and 16 bubbles) -> bubble_cnt stays at all-ones.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB write-through bypass, load-use bubbles, hold and flush
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_memread,
    input  logic              id_regwrite,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       rf_rd1,
    input  logic [31:0]       rf_rd2,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_op1,
    output logic [31:0]       ex_op2,
    output logic              ex_memread,
    output logic              ex_regwrite,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic              valid_q, valid_d, memread_q, memread_d, regwrite_q, regwrite_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       pc_q, pc_d, imm_q, imm_d, op1_q, op1_d, op2_q, op2_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_use, wb_hit1, wb_hit2, ref1, ref2;
    logic [31:0]       byp1, byp2;

    assign load_use = id_valid & valid_q & memread_q & (rd_q != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));
    assign id_stall = (load_use | ex_hold) & ~flush;
    assign wb_hit1  = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == id_rs1);
    assign wb_hit2  = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == id_rs2);
    assign byp1     = wb_hit1 ? wb_data : rf_rd1;
    assign byp2     = wb_hit2 ? wb_data : rf_rd2;
    assign ref1     = valid_q & wb_regwrite & (wb_rd != 5'd0) & (wb_rd == rs1_q);
    assign ref2     = valid_q & wb_regwrite & (wb_rd != 5'd0) & (wb_rd == rs2_q);

    // next-state selection: flush, then hold with operand refresh, then load-use bubble, else capture
    always_comb begin
        valid_d    = valid_q;
        memread_d  = memread_q;
        regwrite_d = regwrite_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        cnt_d      = cnt_q;
        if (flush || (!ex_hold && load_use)) begin
            valid_d    = 1'b0;
            memread_d  = 1'b0;
            regwrite_d = 1'b0;
            ctrl_d     = '0;
            cnt_d      = (!flush && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        end else if (ex_hold) begin
            op1_d = ref1 ? wb_data : op1_q;
            op2_d = ref2 ? wb_data : op2_q;
        end else begin
            valid_d    = id_valid;
            memread_d  = id_valid & id_memread;
            regwrite_d = id_valid & id_regwrite;
            ctrl_d     = id_valid ? id_ctrl : '0;
            pc_d       = id_pc;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            op1_d      = byp1;
            op2_d      = byp2;
        end
    end

    // stage registers with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            memread_q  <= 1'b0;
            regwrite_q <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            memread_q  <= memread_d;
            regwrite_q <= regwrite_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_memread  = memread_q;
    assign ex_regwrite = regwrite_q;
    assign ex_ctrl     = ctrl_q;
    assign ex_pc       = pc_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_op1      = op1_q;
    assign ex_op2      = op2_q;
    assign bubble_cnt  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus hand sequences for hold, flush, saturation and reset
module tb_id_ex_stage;
    localparam int CW = 8;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst, id_valid, id_use_rs1, id_use_rs2, id_memread, id_regwrite;
    logic [31:0]   id_pc, id_imm, rf_rd1, rf_rd2, wb_data;
    logic [4:0]    id_rs1, id_rs2, id_rd, wb_rd;
    logic [CW-1:0] id_ctrl;
    logic          wb_regwrite, flush, ex_hold;
    logic          id_stall, ex_valid, ex_memread, ex_regwrite;
    logic [31:0]   ex_pc, ex_imm, ex_op1, ex_op2;
    logic [4:0]    ex_rs1, ex_rs2, ex_rd;
    logic [CW-1:0] ex_ctrl;
    logic [NW-1:0] bubble_cnt;

    id_ex_stage #(.CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .id_memread(id_memread), .id_regwrite(id_regwrite),
        .id_ctrl(id_ctrl), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .ex_hold(ex_hold),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_ctrl(ex_ctrl),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] valid, pc, imm, rs1, rs2, rd, use1, use2, mr, rw, ctrl, rd1, rd2, wbw, wbrd, wbd;
        logic [31:0] stall, ev, op1, op2, erd, emr, erw, ectrl, ecnt;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_pc = '0; id_imm = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_memread = 1'b0; id_regwrite = 1'b0;
        id_ctrl = '0; rf_rd1 = '0; rf_rd2 = '0; wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; ex_hold = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 0);
        chk({tag, "_mr"}, 32'(ex_memread), 0);
        chk({tag, "_rw"}, 32'(ex_regwrite), 0);
        chk({tag, "_ctrl"}, 32'(ex_ctrl), 0);
        chk({tag, "_pc"}, ex_pc, 0);
        chk({tag, "_imm"}, ex_imm, 0);
        chk({tag, "_idx"}, {17'b0, ex_rs1, ex_rs2, ex_rd}, 0);
        chk({tag, "_op1"}, ex_op1, 0);
        chk({tag, "_op2"}, ex_op2, 0);
        chk({tag, "_cnt"}, 32'(bubble_cnt), 0);
    endtask

    initial begin
        tbl[0]  = '{1,'h100,'h10,6,7,5,1,1,0,1,'h5A,'h5,'h7,1,6,'hAB,   0,1,'hAB,'h7,5,0,1,'h5A,0};
        tbl[1]  = '{1,'h104,'h14,6,7,5,1,1,0,1,'h5A,'h5,'h7,1,0,'hAB,   0,1,'h5,'h7,5,0,1,'h5A,0};
        tbl[2]  = '{1,'h108,'h18,6,7,12,1,1,0,1,'h3C,'h11,'h22,1,7,'hCC, 0,1,'h11,'hCC,12,0,1,'h3C,0};
        tbl[3]  = '{1,'h10C,'h1C,6,7,12,1,1,0,1,'h3C,'h33,'h22,0,6,'hDD, 0,1,'h33,'h22,12,0,1,'h3C,0};
        tbl[4]  = '{1,'h110,'h4,1,2,3,1,1,1,1,'h11,'h1,'h2,0,0,0,       0,1,'h1,'h2,3,1,1,'h11,0};
        tbl[5]  = '{1,'h114,'h8,4,3,8,1,1,0,1,'h22,'h44,'h99,0,0,0,     1,0,'h1,'h2,3,0,0,0,1};
        tbl[6]  = '{1,'h114,'h8,4,3,8,1,1,0,1,'h22,'h44,'h99,1,3,'h77,  0,1,'h44,'h77,8,0,1,'h22,1};
        tbl[7]  = '{1,'h118,0,0,0,3,0,0,1,1,'h01,0,0,0,0,0,             0,1,0,0,3,1,1,'h01,1};
        tbl[8]  = '{1,'h11C,0,5,3,9,1,0,0,1,'h33,'h55,'h66,0,0,0,       0,1,'h55,'h66,9,0,1,'h33,1};
        tbl[9]  = '{0,'h120,0,1,2,10,1,1,1,1,'hFF,'hA,'hB,0,0,0,        0,0,'hA,'hB,10,0,0,0,1};
        tbl[10] = '{1,'h124,0,0,0,0,0,0,1,1,'h02,0,0,0,0,0,             0,1,0,0,0,1,1,'h02,1};
        tbl[11] = '{1,'h128,0,0,0,4,1,1,0,1,'h44,0,0,1,0,'hEE,          0,1,0,0,4,0,1,'h44,1};

        idle();
        id_valid = 1'b1; id_memread = 1'b1; id_regwrite = 1'b1; id_ctrl = 8'hA5;
        id_pc = 32'h1234; rf_rd1 = 32'h55; wb_regwrite = 1'b1; wb_rd = 5'd1; id_rd = 5'd7;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("reset");
        chk("reset_stall", 32'(id_stall), 0);
        idle();

        foreach (tbl[k]) begin
            id_valid = tbl[k].valid[0]; id_pc = tbl[k].pc; id_imm = tbl[k].imm;
            id_rs1 = tbl[k].rs1[4:0]; id_rs2 = tbl[k].rs2[4:0]; id_rd = tbl[k].rd[4:0];
            id_use_rs1 = tbl[k].use1[0]; id_use_rs2 = tbl[k].use2[0];
            id_memread = tbl[k].mr[0]; id_regwrite = tbl[k].rw[0]; id_ctrl = tbl[k].ctrl[7:0];
            rf_rd1 = tbl[k].rd1; rf_rd2 = tbl[k].rd2;
            wb_regwrite = tbl[k].wbw[0]; wb_rd = tbl[k].wbrd[4:0]; wb_data = tbl[k].wbd;
            #1;
            chk($sformatf("v%0d_stall", k), 32'(id_stall), tbl[k].stall);
            tick();
            chk($sformatf("v%0d_valid", k), 32'(ex_valid), tbl[k].ev);
            chk($sformatf("v%0d_op1", k), ex_op1, tbl[k].op1);
            chk($sformatf("v%0d_op2", k), ex_op2, tbl[k].op2);
            chk($sformatf("v%0d_rd", k), 32'(ex_rd), tbl[k].erd);
            chk($sformatf("v%0d_mr", k), 32'(ex_memread), tbl[k].emr);
            chk($sformatf("v%0d_rw", k), 32'(ex_regwrite), tbl[k].erw);
            chk($sformatf("v%0d_ctrl", k), 32'(ex_ctrl), tbl[k].ectrl);
            chk($sformatf("v%0d_cnt", k), 32'(bubble_cnt), tbl[k].ecnt);
        end

        idle();
        id_valid = 1'b1; id_pc = 32'h200; id_imm = 32'h20; id_rs1 = 5'd9; id_rs2 = 5'd10;
        id_rd = 5'd11; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_regwrite = 1'b1;
        id_ctrl = 8'h77; rf_rd1 = 32'h900; rf_rd2 = 32'hA00;
        tick();
        chk("hold_setup_op1", ex_op1, 32'h900);
        id_pc = 32'h204; id_rs1 = 5'd1; id_rd = 5'd2; rf_rd1 = 32'hDEAD; rf_rd2 = 32'hBEEF;
        ex_hold = 1'b1; wb_regwrite = 1'b1; wb_rd = 5'd12; wb_data = 32'hBAD;
        #1;
        chk("hold1_stall", 32'(id_stall), 1);
        tick();
        chk("hold1_op1", ex_op1, 32'h900);
        chk("hold1_op2", ex_op2, 32'hA00);
        chk("hold1_pc", ex_pc, 32'h200);
        wb_rd = 5'd9; wb_data = 32'h1234;
        #1;
        chk("hold2_stall", 32'(id_stall), 1);
        tick();
        chk("hold2_op1", ex_op1, 32'h1234);
        chk("hold2_op2", ex_op2, 32'hA00);
        chk("hold2_pc", ex_pc, 32'h200);
        chk("hold2_imm", ex_imm, 32'h20);
        chk("hold2_idx", {17'b0, ex_rs1, ex_rs2, ex_rd}, {17'b0, 5'd9, 5'd10, 5'd11});
        chk("hold2_valid", 32'(ex_valid), 1);
        chk("hold2_rw", 32'(ex_regwrite), 1);
        chk("hold2_ctrl", 32'(ex_ctrl), 32'h77);
        wb_rd = 5'd10; wb_data = 32'h5555;
        #1;
        chk("hold3_stall", 32'(id_stall), 1);
        tick();
        chk("hold3_op1", ex_op1, 32'h1234);
        chk("hold3_op2", ex_op2, 32'h5555);

        idle();
        id_valid = 1'b1; id_pc = 32'h300; id_rd = 5'd3; id_memread = 1'b1;
        id_regwrite = 1'b1; id_ctrl = 8'h11;
        tick();
        chk("fl_setup_mr", 32'(ex_memread), 1);
        id_pc = 32'h304; id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_rd = 5'd5; id_memread = 1'b0;
        #1;
        chk("fl_lu_stall", 32'(id_stall), 1);
        ex_hold = 1'b1; flush = 1'b1;
        #1;
        chk("fl_stall", 32'(id_stall), 0);
        tick();
        chk("fl_valid", 32'(ex_valid), 0);
        chk("fl_rw", 32'(ex_regwrite), 0);
        chk("fl_mr", 32'(ex_memread), 0);
        chk("fl_ctrl", 32'(ex_ctrl), 0);
        chk("fl_cnt", 32'(bubble_cnt), 1);
        chk("fl_pc", ex_pc, 32'h300);

        idle();
        id_valid = 1'b1; id_pc = 32'h400; id_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
        id_memread = 1'b1; id_regwrite = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 10) chk("sat_mid_cnt", 32'(bubble_cnt), 6);
        end
        chk("sat_cnt", 32'(bubble_cnt), 15);
        tick();
        chk("rst_pre_valid", 32'(ex_valid), 1);
        ex_hold = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; ex_hold = 1'b0;
        chk_zero("midrst");
        #1;
        chk("midrst_stall", 32'(id_stall), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
